mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares the 8-input mux datapath (mux_8x1) between eight requesters. It drives the mux select lines sel0/sel1/sel2 and a one-hot grant vector. Each grant lasts a bounded burst, and the arbiter hands over to the next requester with no idle cycle. It sits directly in front of mux_8x1: sel outputs connect 1:1 to its select inputs, and requester i owns mux data input Ii.

Parameters:
MAX_BURST, 4, max consecutive cycles one requester holds the grant (legal 1..15)
CNT_W, 4, width of burst counter; must hold MAX_BURST

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  arbitration enable; 0 = release and no new grants
req  input  8  request per mux input; req[i] ↔ Ii
grant  output  8  one-hot grant, registered; all-zero when idle
sel0  output  1  select bit 0 (LSB of granted index), registered
sel1  output  1  select bit 1, registered
sel2  output  1  select bit 2 (MSB), registered
busy  output  1  1 while any grant is active

Behaviour:
- All outputs registered. One clock domain, clk. rst is synchronous and active-high, and overrides everything at the next edge.
- Reset values:
  - grant=8'h00, {sel2,sel1,sel0}=3'b000, busy=0.
  - state=IDLE, last pointer=7 (first priority to index 0), burst_cnt=0.
- Winner selection (combinational): search order last+1, last+2, ... wrapping mod 8, ending at last. The first asserted req bit wins. The last granted index therefore has lowest priority.
- States:
  - IDLE: if en && |req at an edge, the next cycle gives grant=onehot(winner), sel=winner, busy=1, burst_cnt=1, last=winner, state=GRANT. Latency: req sampled at edge N gives grant visible after edge N+1, one cycle.
  - GRANT, hold condition: en && req[cur] && burst_cnt<MAX_BURST. Keep grant and sel, burst_cnt+1.
  - GRANT, handover: hold false but en && |req. Re-arbitrate in the same edge using last=cur. The new winner gets the grant on the next cycle with burst_cnt=1 and no bubble. If only cur still requests after burst expiry, cur is re-granted: grant stays continuous and burst_cnt restarts at 1.
  - GRANT, release: en=0 or req==0. Next cycle grant=0, busy=0, state=IDLE.
- sel behaviour: sel holds its last value in IDLE; it never returns to 000 except on reset. This keeps the mux output stable.
- Request withdrawal: req[cur] is sampled, so the grant persists for exactly one cycle after req[cur] falls. Requesters must tolerate this.
- Other req bits: changes to non-granted bits have no effect until the next arbitration point.
- en=0 mid-grant: grant drops at the next edge. last is retained, so when en returns, priority resumes from last+1.
- rst mid-grant: outputs return to reset values at the next edge and last resets to 7.
- MAX_BURST=1: pure per-cycle round robin.
- Invariants: grant is always one-hot or zero. When busy=1, grant==onehot({sel2,sel1,sel0}). busy==|grant.

Decomposition:
- Shared package/header mux8_arb_pkg:
  - NUM_REQ=8, SEL_W=3.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Default MAX_BURST.
- One sub-module, rr_pick8 (combinational): inputs req[7:0] and last[2:0]; outputs winner[2:0] and found. Implemented as a rotate, fixed-priority encode, then un-rotate.
- The top level holds the FSM, burst counter, last pointer and output registers.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=8'hFF -> grant=00, sel=000, busy=0 throughout. After release, first grant=8'h01, sel=000.
2. Single holder: req=8'h04 held 12 cycles -> grant=8'h04 and sel=010 continuously from cycle 1 after req, no gap at burst boundaries. burst_cnt pattern 1,2,3,4,1,...
3. Contention/wrap: req=8'h81 held -> grant alternates 01 for 4 cycles, then 80 for 4 cycles, repeating; sel 000/111. No idle cycle between bursts.
4. Early release: req=8'h08 for 2 cycles then 0 -> grant=08 for 2 cycles (one-cycle lag), then grant=00, busy=0, sel stays 011.
5. Enable drop: during grant to index 5, en=0 for 3 cycles with req=8'h60 -> grant=00 from next edge. On en=1, grant=8'h40 (index 6 after last=5), sel=110.
6. Mid-operation reset: rst pulse while grant=8'h10 with req=8'hFF -> reset values next cycle. Then grant=8'h01, i.e. the pointer was reset.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux8_arb_pkg;

    localparam int NUM_REQ           = 8;
    localparam int SEL_W             = 3;
    localparam int DEFAULT_MAX_BURST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin winner search over 8 requests, starting just after the last granted index.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is asserted.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   winner,
    output logic               found
);

    logic [SEL_W-1:0]   start;
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   idx;

    assign start = last + 3'd1;

    // rot[0] is the highest-priority candidate (last+1); the 3-bit sum wraps mod 8.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[start + 3'(i)];
        end
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
    end

    assign winner = idx + start;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving mux_8x1 select lines and a one-hot grant, bounded bursts.
// Latency: request sampled at edge N is granted after edge N+1; handover has no idle cycle.
// Backpressure: en=0 or no requests releases the grant at the next edge; sel holds in idle.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               sel0,
    output logic               sel1,
    output logic               sel2,
    output logic               busy
);

    arb_state_t         state_q, state_nxt;
    logic [SEL_W-1:0]   last_q, last_nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic               busy_q, busy_nxt;

    logic [SEL_W-1:0]   winner;
    logic               found;
    logic [NUM_REQ-1:0] onehot;
    logic               hold;

    // While granted, last_q is the current holder, so one picker serves both idle and handover.
    rr_pick8 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        onehot         = '0;
        onehot[winner] = 1'b1;
    end

    assign hold = en && req[last_q] && (cnt_q < CNT_W'(MAX_BURST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            sel_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            last_q  <= last_nxt;
            sel_q   <= sel_nxt;
            cnt_q   <= cnt_nxt;
            grant_q <= grant_nxt;
            busy_q  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (en && found) state_nxt = GRANT;
            GRANT:   if (!hold && !(en && found)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last_nxt  = last_q;
        sel_nxt   = sel_q;
        cnt_nxt   = cnt_q;
        grant_nxt = grant_q;
        busy_nxt  = busy_q;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    last_nxt  = winner;
                    sel_nxt   = winner;
                    cnt_nxt   = CNT_W'(1);
                    grant_nxt = onehot;
                    busy_nxt  = 1'b1;
                end else begin
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end
            end
            GRANT: begin
                if (hold) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end else if (en && found) begin
                    // Burst boundary: may re-pick the same holder if it is the only requester.
                    last_nxt  = winner;
                    sel_nxt   = winner;
                    cnt_nxt   = CNT_W'(1);
                    grant_nxt = onehot;
                    busy_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = '0;
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign grant = grant_q;
    assign sel0  = sel_q[0];
    assign sel1  = sel_q[1];
    assign sel2  = sel_q[2];
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboarded bench: directed scenarios then random traffic against a queue-based reference model.
module tb_mux8_rr_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic       sel0, sel1, sel2, busy;

    mux8_rr_arbiter #(.MAX_BURST(MAXB), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .grant (grant),
        .sel0  (sel0),
        .sel1  (sel1),
        .sel2  (sel2),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: holder index, burst length so far, pointer and visible select.
    bit m_active = 0;
    int m_holder = 7;
    int m_burst  = 0;
    int m_sel    = 0;

    function automatic int rr_search(input logic [7:0] r, input int after);
        for (int k = 1; k <= 8; k++) begin
            if (r[(after + k) % 8]) return (after + k) % 8;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic r_rst, input logic r_en, input logic [7:0] r_req);
        int w;
        if (r_rst) begin
            m_active = 0; m_holder = 7; m_burst = 0; m_sel = 0;
            return;
        end
        if (m_active && r_en && r_req[m_holder] && m_burst < MAXB) begin
            m_burst++;
            return;
        end
        w = rr_search(r_req, m_holder);
        if (r_en && w >= 0) begin
            m_active = 1; m_holder = w; m_sel = w; m_burst = 1;
        end else begin
            m_active = 0; m_burst = 0;
        end
    endfunction

    task automatic apply(input logic r_rst, input logic r_en, input logic [7:0] r_req, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r_rst;
        en  = r_en;
        req = r_req;
        model_step(r_rst, r_en, r_req);
        e.grant = m_active ? (8'h01 << m_holder) : 8'h00;
        e.sel   = 3'(m_sel);
        e.busy  = m_active;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: the outputs are registered, so one expected entry matures per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (grant !== e.grant || {sel2, sel1, sel0} !== e.sel || busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s t=%0t grant=%h want %h sel=%b want %b busy=%b want %b",
                             e.tag, $time, grant, e.grant, {sel2, sel1, sel0}, e.sel, busy, e.busy);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic       e_bit;
        logic       r_bit;

        // Reset with all requests asserted, then first grant goes to index 0.
        apply(1, 1, 8'hFF, "reset");
        apply(1, 1, 8'hFF, "reset");
        apply(0, 1, 8'hFF, "first_grant");
        apply(0, 0, 8'h00, "idle");

        // Lone requester keeps the grant continuously across burst boundaries.
        for (int i = 0; i < 12; i++) apply(0, 1, 8'h04, "single_holder");
        apply(0, 1, 8'h00, "single_release");

        // Two requesters at the wrap point alternate in bursts with no gap.
        for (int i = 0; i < 18; i++) apply(0, 1, 8'h81, "wrap_contention");
        apply(0, 1, 8'h00, "wrap_release");

        // Early release: grant lags the request by one cycle, sel holds afterwards.
        apply(0, 1, 8'h08, "early_release");
        apply(0, 1, 8'h08, "early_release");
        for (int i = 0; i < 3; i++) apply(0, 1, 8'h00, "early_idle");

        // Enable drop mid-grant to index 5, then priority resumes at index 6.
        apply(0, 1, 8'h20, "en_setup");
        apply(0, 1, 8'h20, "en_setup");
        for (int i = 0; i < 3; i++) apply(0, 0, 8'h60, "en_drop");
        for (int i = 0; i < 3; i++) apply(0, 1, 8'h60, "en_resume");
        apply(0, 1, 8'h00, "en_release");

        // Reset pulse while index 4 holds; pointer must restart so index 0 wins.
        apply(0, 1, 8'h10, "midrst_setup");
        apply(0, 1, 8'h10, "midrst_setup");
        apply(1, 1, 8'hFF, "midrst_pulse");
        apply(0, 1, 8'hFF, "midrst_after");
        apply(0, 1, 8'hFF, "midrst_after");

        // Random traffic: sparse requests, occasional enable drops and rare resets.
        for (int i = 0; i < 2000; i++) begin
            r     = 8'($urandom) & 8'($urandom) ;
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            e_bit = ($urandom_range(0, 15) != 0);
            r_bit = ($urandom_range(0, 199) == 0);
            apply(r_bit, e_bit, r, "random");
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
